// File: rtl/dma_read_arbiter.sv
// Two-requester arbiter for the shared DMA read ctrl/data channel.
// Optional DMA_RD_ARB_RR_EN: round-robin tie-break instead of fixed req0 priority.
module dma_read_arbiter #(
    parameter int DMA_DATA_WIDTH = 32,
    parameter int CTRL_WIDTH     = 67
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_ctrl_valid,
    output logic                      req0_ctrl_ready,
    input  logic [CTRL_WIDTH-1:0]     req0_ctrl_data,
    input  logic                      req1_ctrl_valid,
    output logic                      req1_ctrl_ready,
    input  logic [CTRL_WIDTH-1:0]     req1_ctrl_data,
    output logic                      req0_chnl_valid,
    input  logic                      req0_chnl_ready,
    output logic [DMA_DATA_WIDTH-1:0] req0_chnl_data,
    output logic                      req1_chnl_valid,
    input  logic                      req1_chnl_ready,
    output logic [DMA_DATA_WIDTH-1:0] req1_chnl_data,
    output logic                      dma_read_ctrl_valid,
    input  logic                      dma_read_ctrl_ready,
    output logic [CTRL_WIDTH-1:0]     dma_read_ctrl_data,
    input  logic                      dma_read_chnl_valid,
    output logic                      dma_read_chnl_ready,
    input  logic [DMA_DATA_WIDTH-1:0] dma_read_chnl_data,
    output logic [1:0]                grant,
    output logic                      busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CTRL = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [31:0]           len_q, len_d;
    logic [31:0]           beat_cnt_q, beat_cnt_d;
    logic [CTRL_WIDTH-1:0] ctrl_sel;
    logic                  in_ctrl, in_data, ctrl_hs, chnl_hs, pick1;

    assign in_ctrl  = (state_q == S_CTRL);
    assign in_data  = (state_q == S_DATA);
    assign ctrl_sel = grant_q[1] ? req1_ctrl_data : req0_ctrl_data;

    assign dma_read_ctrl_valid = in_ctrl;
    assign dma_read_ctrl_data  = in_ctrl ? ctrl_sel : '0;
    assign req0_ctrl_ready     = in_ctrl & grant_q[0] & dma_read_ctrl_ready;
    assign req1_ctrl_ready     = in_ctrl & grant_q[1] & dma_read_ctrl_ready;

    // Beat path is purely combinational; the non-owner never sees valid.
    assign dma_read_chnl_ready = in_data & (grant_q[1] ? req1_chnl_ready : req0_chnl_ready);
    assign req0_chnl_valid     = in_data & grant_q[0] & dma_read_chnl_valid;
    assign req1_chnl_valid     = in_data & grant_q[1] & dma_read_chnl_valid;
    assign req0_chnl_data      = dma_read_chnl_data;
    assign req1_chnl_data      = dma_read_chnl_data;

    assign ctrl_hs = in_ctrl & dma_read_ctrl_ready;
    assign chnl_hs = dma_read_chnl_ready & dma_read_chnl_valid;

    assign grant = grant_q;
    assign busy  = (state_q != S_IDLE);

`ifdef DMA_RD_ARB_RR_EN
    // On a tie, the requester that did not win last time goes next.
    assign pick1 = req1_ctrl_valid & (~req0_ctrl_valid | ~last_grant_q);
`else
    assign pick1 = req1_ctrl_valid & ~req0_ctrl_valid;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req0_ctrl_valid | req1_ctrl_valid) begin
                    grant_d      = pick1 ? 2'b10 : 2'b01;
                    last_grant_d = pick1;
                    state_d      = S_CTRL;
                end
            end
            S_CTRL: begin
                if (ctrl_hs) begin
                    len_d      = ctrl_sel[63:32];
                    beat_cnt_d = '0;
                    if (ctrl_sel[63:32] == 32'd0) begin
                        state_d = S_IDLE;
                        grant_d = 2'b00;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (chnl_hs) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    if (beat_cnt_q == len_q - 32'd1) begin
                        state_d = S_IDLE;
                        grant_d = 2'b00;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 1'b1;
            len_q        <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_dma_read_arbiter.sv
// Self-checking bench for dma_read_arbiter; honours DMA_RD_ARB_RR_EN when defined.
module tb_dma_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rcv;
    logic [1:0]  rchr;
    logic [66:0] rcd0, rcd1;
    logic        r0cr, r1cr, r0chv, r1chv;
    logic [31:0] r0chd, r1chd;
    logic        dma_ccv, dma_ccr;
    logic [66:0] dma_ccd;
    logic        dma_cv, dma_chr;
    logic [31:0] dma_cd;
    logic [1:0]  grant;
    logic        busy;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dma_read_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_ctrl_valid(rcv[0]), .req0_ctrl_ready(r0cr), .req0_ctrl_data(rcd0),
        .req1_ctrl_valid(rcv[1]), .req1_ctrl_ready(r1cr), .req1_ctrl_data(rcd1),
        .req0_chnl_valid(r0chv), .req0_chnl_ready(rchr[0]), .req0_chnl_data(r0chd),
        .req1_chnl_valid(r1chv), .req1_chnl_ready(rchr[1]), .req1_chnl_data(r1chd),
        .dma_read_ctrl_valid(dma_ccv), .dma_read_ctrl_ready(dma_ccr), .dma_read_ctrl_data(dma_ccd),
        .dma_read_chnl_valid(dma_cv), .dma_read_chnl_ready(dma_chr), .dma_read_chnl_data(dma_cd),
        .grant(grant), .busy(busy)
    );

    function automatic logic [66:0] mkctrl(input logic [31:0] len, input logic [31:0] idx);
        return {3'd2, len, idx};
    endfunction

    // Drives DMA beats for the owner r; pops the scoreboard on each owner handshake.
    task automatic serve(input int r, input int len, input logic [31:0] base,
                         input int stall_at, input int stall_n, input bit drop);
        int got = 0;
        int stalled = 0;
        int cyc = 0;
        logic v, d_ok;
        logic [31:0] d, e;
        while (got < len && cyc < 60) begin
            @(negedge clk);
            if (drop) rcv[r] = 1'b0;
            dma_cv = 1'b1;
            dma_cd = base + got;
            rchr[r] = !(got == stall_at && stalled < stall_n);
            rchr[1-r] = 1'b1;
            #1;
            v = (r == 0) ? r0chv : r1chv;
            d = (r == 0) ? r0chd : r1chd;
            checks++;
            if (dma_chr !== rchr[r]) begin
                failures++;
                $display("FAIL chnl_ready_route got=%0b exp=%0b beat=%0d", dma_chr, rchr[r], got);
            end
            checks++;
            if (((r == 0) ? r1chv : r0chv) !== 1'b0) begin
                failures++;
                $display("FAIL other_chnl_valid got=1 exp=0 owner=%0d", r);
            end
            if (!rchr[r]) stalled++;
            if (v && rchr[r]) begin
                e = exp_q.pop_front();
                d_ok = (d === e);
                checks++;
                if (!d_ok) begin
                    failures++;
                    $display("FAIL beat_data got=%0h exp=%0h", d, e);
                end
                got++;
            end
            cyc++;
        end
        checks++;
        if (got != len) begin
            failures++;
            $display("FAIL beat_count got=%0d exp=%0d (timeout)", got, len);
        end
        @(negedge clk);
        dma_cv = 1'b0;
        rchr = 2'b00;
        #1;
        checks++;
        if (busy !== 1'b0 || grant !== 2'b00) begin
            failures++;
            $display("FAIL release got busy=%0b grant=%0b exp busy=0 grant=00", busy, grant);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; rcv = 2'b00; rchr = 2'b00; rcd0 = '0; rcd1 = '0;
        dma_ccr = 1'b0; dma_cv = 1'b0; dma_cd = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({grant, busy, dma_ccv, dma_chr, r0cr, r1cr, r0chv, r1chv} !== 9'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h exp=0", {grant, busy, dma_ccv, dma_chr, r0cr, r1cr, r0chv, r1chv});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [66:0] w;
        w = mkctrl(32'd4, 32'h10);
        @(negedge clk);
        rcd0 = w; rcv[0] = 1'b1; dma_ccr = 1'b1;
        #1;
        checks++;
        if (dma_ccv !== 1'b0) begin
            failures++;
            $display("FAIL single_idle_ctrl_valid got=%0b exp=0", dma_ccv);
        end
        @(negedge clk); #1;
        checks++;
        if (dma_ccv !== 1'b1 || dma_ccd !== w) begin
            failures++;
            $display("FAIL single_ctrl got valid=%0b data=%0h exp valid=1 data=%0h", dma_ccv, dma_ccd, w);
        end
        checks++;
        if (grant !== 2'b01 || busy !== 1'b1 || r0cr !== 1'b1 || r1cr !== 1'b0) begin
            failures++;
            $display("FAIL single_grant got grant=%0b busy=%0b r0cr=%0b r1cr=%0b exp 01 1 1 0", grant, busy, r0cr, r1cr);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
        serve(0, 4, 32'hA0, -1, 0, 1'b1);
    endtask

    task automatic test_tie();
        logic [1:0] eg;
        int rounds;
        rcd0 = mkctrl(32'd2, 32'h100);
        rcd1 = mkctrl(32'd2, 32'h200);
        dma_ccr = 1'b1;
`ifdef DMA_RD_ARB_RR_EN
        rounds = 4;
`else
        rounds = 5;
`endif
        @(negedge clk);
        rcv = 2'b11;
        for (int i = 0; i < rounds; i++) begin
`ifdef DMA_RD_ARB_RR_EN
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            eg = (i < 4) ? 2'b01 : 2'b10;
`endif
            @(negedge clk); #1;
            checks++;
            if (grant !== eg) begin
                failures++;
                $display("FAIL tie_grant round=%0d got=%0b exp=%0b", i, grant, eg);
            end
            checks++;
            if (dma_ccd !== (eg[1] ? rcd1 : rcd0)) begin
                failures++;
                $display("FAIL tie_ctrl_data round=%0d got=%0h exp=%0h", i, dma_ccd, eg[1] ? rcd1 : rcd0);
            end
            for (int k = 0; k < 2; k++) exp_q.push_back(32'h300 + 16 * i + k);
            serve(eg[1] ? 1 : 0, 2, 32'h300 + 16 * i, -1, 0, 1'b0);
            if (i == 3) rcv[0] = 1'b0;
        end
        rcv = 2'b00;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        rcd1 = mkctrl(32'd3, 32'h40); rcv[1] = 1'b1; dma_ccr = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (grant !== 2'b10 || r1cr !== 1'b1 || r0cr !== 1'b0) begin
            failures++;
            $display("FAIL bp_grant got grant=%0b r1cr=%0b r0cr=%0b exp 10 1 0", grant, r1cr, r0cr);
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(32'hB0 + i);
        serve(1, 3, 32'hB0, 1, 2, 1'b1);
    endtask

    task automatic test_ctrl_stall();
        logic [66:0] w;
        w = mkctrl(32'd1, 32'h55);
        @(negedge clk);
        rcd0 = w; rcv[0] = 1'b1; dma_ccr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (dma_ccv !== 1'b1 || dma_ccd !== w || r0cr !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got valid=%0b data=%0h ready=%0b exp 1 %0h 0", i, dma_ccv, dma_ccd, r0cr, w);
            end
        end
        @(negedge clk);
        dma_ccr = 1'b1;
        #1;
        checks++;
        if (r0cr !== 1'b1 || dma_ccv !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got ready=%0b valid=%0b exp 1 1", r0cr, dma_ccv);
        end
        exp_q.push_back(32'hE0);
        serve(0, 1, 32'hE0, -1, 0, 1'b1);
    endtask

    task automatic test_len0();
        @(negedge clk);
        rcd0 = mkctrl(32'd0, 32'h77); rcv[0] = 1'b1; dma_ccr = 1'b1;
        dma_cv = 1'b1; dma_cd = 32'hDEAD; rchr = 2'b11;
        @(negedge clk); #1;
        checks++;
        if (dma_ccv !== 1'b1 || dma_chr !== 1'b0) begin
            failures++;
            $display("FAIL len0_ctrl got valid=%0b chnl_ready=%0b exp 1 0", dma_ccv, dma_chr);
        end
        @(negedge clk);
        rcv[0] = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || grant !== 2'b00) begin
            failures++;
            $display("FAIL len0_idle got busy=%0b grant=%0b exp 0 00", busy, grant);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (dma_chr !== 1'b0 || r0chv !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL len0_stray got chnl_ready=%0b r0chv=%0b busy=%0b exp 0 0 0", dma_chr, r0chv, busy);
            end
        end
        dma_cv = 1'b0; rchr = 2'b00;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rcd0 = mkctrl(32'd8, 32'h88); rcv[0] = 1'b1; dma_ccr = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rcv[0] = 1'b0; dma_cv = 1'b1; dma_cd = 32'hC0 + i; rchr[0] = 1'b1;
            #1;
            checks++;
            if (r0chv !== 1'b1 || r0chd !== 32'hC0 + i) begin
                failures++;
                $display("FAIL mid_beat i=%0d got valid=%0b data=%0h exp 1 %0h", i, r0chv, r0chd, 32'hC0 + i);
            end
        end
        @(negedge clk);
        dma_cd = 32'hC2;
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({grant, busy, dma_ccv, dma_chr, r0cr, r1cr, r0chv, r1chv} !== 9'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%0h exp=0", {grant, busy, dma_ccv, dma_chr, r0cr, r1cr, r0chv, r1chv});
        end
        @(negedge clk);
        dma_cv = 1'b0; rchr = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rcd1 = mkctrl(32'd2, 32'h99); rcv[1] = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (grant !== 2'b10 || dma_ccd !== rcd1) begin
            failures++;
            $display("FAIL post_reset_grant got grant=%0b data=%0h exp 10 %0h", grant, dma_ccd, rcd1);
        end
        exp_q.push_back(32'hD0);
        exp_q.push_back(32'hD1);
        serve(1, 2, 32'hD0, -1, 0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_ctrl_stall();
        test_len0();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
